// File: rtl/pll_pkg.sv
// Shared types and defaults for the PLL lock supervisor.
package pll_pkg;

    // Supervisor FSM states.
    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } pll_state_e;

    // Defaults sized for a 50 MHz reference clock.
    localparam int RST_PULSE_CYC_DEF    = 16;
    localparam int LOCK_TIMEOUT_CYC_DEF = 50000;
    localparam int LOCK_STABLE_CYC_DEF  = 1024;
    localparam int RETRY_MAX_DEF        = 7;

    localparam int LOSS_CNT_W = 8;

    // Largest of three values, used to size the shared cycle counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops; only sync_q is safe to consume.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences the PLL reset, qualifies lock and gates the
// system reset. Runs on the free-running reference clock only.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// RESET_PLL | pll_rst held high for RST_PULSE_CYC cycles
// WAIT_LOCK | pll_rst released, waiting for synchronized lock (with timeout)
// STABLE    | lock seen, counting LOCK_STABLE_CYC consecutive locked cycles
// RUN       | system reset released, ready high; lock loss re-runs PLL reset
// FAIL      | retries exhausted; idle until rst_n or relock_req
module pll_lock_supervisor
    import pll_pkg::*;
#(
    parameter int RST_PULSE_CYC    = RST_PULSE_CYC_DEF,
    parameter int LOCK_TIMEOUT_CYC = LOCK_TIMEOUT_CYC_DEF,
    parameter int LOCK_STABLE_CYC  = LOCK_STABLE_CYC_DEF,
    parameter int RETRY_MAX        = RETRY_MAX_DEF
) (
    input  logic                  refclk_i,
    input  logic                  rst_n_i,
    input  logic                  locked_i,
    input  logic                  relock_req_i,
    output logic                  pll_rst_o,
    output logic                  sys_rst_n_o,
    output logic                  ready_o,
    output logic                  fail_o,
    output logic [LOSS_CNT_W-1:0] loss_cnt_o
);

    localparam int CNT_W   = $clog2(max3(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC)) + 1;
    localparam int RETRY_W = $clog2(RETRY_MAX + 1);

    // Terminal counts: the counter starts at 0 on state entry, so the
    // decision edge is the one where it equals N-1.
    localparam logic [CNT_W-1:0]   RST_TC    = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_TC = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0]   STABLE_TC = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_TC  = RETRY_W'(RETRY_MAX);

    pll_state_e              state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [RETRY_W-1:0]      retry_q;
    logic [LOSS_CNT_W-1:0]   loss_q;
    logic                    pll_rst_q;
    logic                    sys_rst_n_q;
    logic                    ready_q;
    logic                    fail_q;
    logic                    locked_s;

    sync_2ff u_sync_locked (
        .clk_i  (refclk_i),
        .rst_ni (rst_n_i),
        .d_i    (locked_i),
        .q_o    (locked_s)
    );

    // Supervisor FSM with registered outputs updated on each transition.
    always_ff @(posedge refclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= RESET_PLL;
            cnt_q       <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else if (relock_req_i) begin
            // Request wins over any simultaneous loss or timeout.
            state_q     <= RESET_PLL;
            cnt_q       <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
            if (state_q == FAIL) begin
                retry_q <= '0;
            end
        end else begin
            case (state_q)
                RESET_PLL: begin
                    if (cnt_q == RST_TC) begin
                        state_q   <= WAIT_LOCK;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_q <= STABLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == TIMEOUT_TC) begin
                        cnt_q <= '0;
                        if (retry_q == RETRY_TC) begin
                            state_q <= FAIL;
                            fail_q  <= 1'b1;
                        end else begin
                            state_q   <= RESET_PLL;
                            retry_q   <= retry_q + RETRY_W'(1);
                            pll_rst_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                STABLE: begin
                    if (!locked_s) begin
                        // Chatter: restart the timeout window, not a failed attempt.
                        state_q <= WAIT_LOCK;
                        cnt_q   <= '0;
                    end else if (cnt_q == STABLE_TC) begin
                        state_q     <= RUN;
                        cnt_q       <= '0;
                        retry_q     <= '0;
                        sys_rst_n_q <= 1'b1;
                        ready_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        state_q     <= RESET_PLL;
                        cnt_q       <= '0;
                        pll_rst_q   <= 1'b1;
                        sys_rst_n_q <= 1'b0;
                        ready_q     <= 1'b0;
                        if (loss_q != '1) begin
                            loss_q <= loss_q + LOSS_CNT_W'(1);
                        end
                    end
                end
                FAIL: begin
                    pll_rst_q   <= 1'b0;
                    sys_rst_n_q <= 1'b0;
                    ready_q     <= 1'b0;
                    fail_q      <= 1'b1;
                end
                default: begin
                    state_q     <= RESET_PLL;
                    cnt_q       <= '0;
                    pll_rst_q   <= 1'b1;
                    sys_rst_n_q <= 1'b0;
                    ready_q     <= 1'b0;
                    fail_q      <= 1'b0;
                end
            endcase
        end
    end

    assign pll_rst_o   = pll_rst_q;
    assign sys_rst_n_o = sys_rst_n_q;
    assign ready_o     = ready_q;
    assign fail_o      = fail_q;
    assign loss_cnt_o  = loss_q;

endmodule
